// File: rtl/ram_to_vga.sv
// ---------------------------------------------------------------------------
// ram_to_vga
// Read side of the frame buffer. Generates VGA timing (640x480@60 by
// default), fetches pixels of a centered run-time-sized image from the frame
// RAM read port and drives an 8-bit grey pixel bus, black outside the image.
//
// Optional feature macro: BORDER_EN
//   When defined, a one-pixel white (8'hFF) ring is drawn just outside the
//   image window, clipped to the visible area, regardless of frame_valid.
//
// Ports:
//   clk          pixel clock, rising edge
//   reset        asynchronous active-high reset
//   img_w/img_h  image size (latched once per frame, clamped to 1..VIS)
//   frame_valid  frame buffer holds a complete image (latched once per frame)
//   ram_rdaddr   frame RAM read address (registered, holds when idle)
//   ram_rden     read enable for in-window fetches (registered)
//   ram_rddata   frame RAM data, valid RD_LAT cycles after ram_rdaddr
//   pixel        grey pixel out
//   blank        high outside the visible area
//   hsync/vsync  active-low syncs
//   frame_start  one-cycle pulse with the first visible pixel of a frame
// pixel/blank/hsync/vsync/frame_start lag the counters by RD_LAT+1 cycles.
// ---------------------------------------------------------------------------
module ram_to_vga #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  img_w,
    input  logic [9:0]  img_h,
    input  logic        frame_valid,
    output logic [18:0] ram_rdaddr,
    output logic        ram_rden,
    input  logic [7:0]  ram_rddata,
    output logic [7:0]  pixel,
    output logic        blank,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0]  H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOT - 1);
    localparam logic [10:0] H_VIS_W  = 11'(H_VIS);
    localparam logic [10:0] V_VIS_W  = 11'(V_VIS);
    localparam logic [10:0] HS_START = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_VIS + V_FP + V_SYNC);

    // Per-pixel control that travels alongside the RAM read latency.
    typedef struct packed {
        logic blank;
        logic hsync;
        logic vsync;
        logic fs;
        logic use_ram;
`ifdef BORDER_EN
        logic border;
`endif
    } ctl_t;

    localparam ctl_t CTL_RST = '{blank: 1'b1, hsync: 1'b1, vsync: 1'b1, default: 1'b0};

    // Clamp a latched dimension into 1..max.
    function automatic logic [9:0] clamp_dim(input logic [9:0] v, input logic [9:0] max);
        logic [9:0] r;
        if (v == 10'd0) begin
            r = 10'd1;
        end else if (v > max) begin
            r = max;
        end else begin
            r = v;
        end
        return r;
    endfunction

    logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0]  wl_q, wl_d, hl_q, hl_d;
    logic        fv_q, fv_d;
    logic [18:0] addr_q, addr_d;
    logic [18:0] rdaddr_q, rdaddr_d;
    logic        rden_q;
    logic [10:0] hx_s, vy_s, x0_s, y0_s, x_end_s, y_end_s;
    logic        in_win_s, vis_s, fetch_s, frame_end_s;
    ctl_t        ctl_s;
    ctl_t        pipe_q [RD_LAT];
    logic [7:0]  pixel_q, pixel_d;
    logic        blank_q, hsync_q, vsync_q, fs_q;

    // Window geometry and per-position decode from the current counters.
    always_comb begin
        hx_s        = {1'b0, h_cnt_q};
        vy_s        = {1'b0, v_cnt_q};
        x0_s        = (H_VIS_W - {1'b0, wl_q}) >> 1;
        y0_s        = (V_VIS_W - {1'b0, hl_q}) >> 1;
        x_end_s     = x0_s + {1'b0, wl_q};
        y_end_s     = y0_s + {1'b0, hl_q};
        in_win_s    = (hx_s >= x0_s) && (hx_s < x_end_s) && (vy_s >= y0_s) && (vy_s < y_end_s);
        vis_s       = (hx_s < H_VIS_W) && (vy_s < V_VIS_W);
        fetch_s     = in_win_s && fv_q;
        frame_end_s = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);

        ctl_s         = CTL_RST;
        ctl_s.blank   = ~vis_s;
        ctl_s.hsync   = ~((hx_s >= HS_START) && (hx_s < HS_END));
        ctl_s.vsync   = ~((vy_s >= VS_START) && (vy_s < VS_END));
        ctl_s.fs      = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
        ctl_s.use_ram = fetch_s;
`ifdef BORDER_EN
        // Ring = the window grown by one pixel on each side, minus the window.
        // Comparing hx+1 >= x0 avoids underflow when x0 is 0.
        ctl_s.border  = vis_s && !in_win_s
                        && (hx_s + 11'd1 >= x0_s) && (hx_s <= x_end_s)
                        && (vy_s + 11'd1 >= y0_s) && (vy_s <= y_end_s);
`endif
    end

    // Next-state for counters, frame latch and incremental address.
    always_comb begin
        h_cnt_d  = h_cnt_q;
        v_cnt_d  = v_cnt_q;
        wl_d     = wl_q;
        hl_d     = hl_q;
        fv_d     = fv_q;
        addr_d   = addr_q;
        rdaddr_d = rdaddr_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = 10'd0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = 10'd0;
            end else begin
                v_cnt_d = v_cnt_q + 10'd1;
            end
        end else begin
            h_cnt_d = h_cnt_q + 10'd1;
        end
        if (frame_end_s) begin
            wl_d   = clamp_dim(img_w, 10'(H_VIS));
            hl_d   = clamp_dim(img_h, 10'(V_VIS));
            fv_d   = frame_valid;
            addr_d = 19'd0;
        end else if (fetch_s) begin
            addr_d = addr_q + 19'd1;
        end else begin
            addr_d = addr_q;
        end
        if (fetch_s) begin
            rdaddr_d = addr_q;
        end else begin
            rdaddr_d = rdaddr_q;
        end
    end

    // Timing counters, latched frame geometry and read address state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt_q  <= 10'd0;
            v_cnt_q  <= 10'd0;
            wl_q     <= 10'd1;
            hl_q     <= 10'd1;
            fv_q     <= 1'b0;
            addr_q   <= 19'd0;
            rdaddr_q <= 19'd0;
            rden_q   <= 1'b0;
        end else begin
            h_cnt_q  <= h_cnt_d;
            v_cnt_q  <= v_cnt_d;
            wl_q     <= wl_d;
            hl_q     <= hl_d;
            fv_q     <= fv_d;
            addr_q   <= addr_d;
            rdaddr_q <= rdaddr_d;
            rden_q   <= fetch_s;
        end
    end

    // Pixel source select at the point where ram_rddata belongs to this pixel.
    always_comb begin
        pixel_d = 8'h00;
        if (pipe_q[RD_LAT-1].use_ram) begin
            pixel_d = ram_rddata;
        end
`ifdef BORDER_EN
        else if (pipe_q[RD_LAT-1].border) begin
            pixel_d = 8'hFF;
        end
`endif
        else begin
            pixel_d = 8'h00;
        end
    end

    // Control delay line (RD_LAT stages) followed by the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= CTL_RST;
            end
            pixel_q <= 8'h00;
            blank_q <= 1'b1;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            pipe_q[0] <= ctl_s;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
            pixel_q <= pixel_d;
            blank_q <= pipe_q[RD_LAT-1].blank;
            hsync_q <= pipe_q[RD_LAT-1].hsync;
            vsync_q <= pipe_q[RD_LAT-1].vsync;
            fs_q    <= pipe_q[RD_LAT-1].fs;
        end
    end

    assign ram_rdaddr  = rdaddr_q;
    assign ram_rden    = rden_q;
    assign pixel       = pixel_q;
    assign blank       = blank_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_ram_to_vga.sv
// ---------------------------------------------------------------------------
// tb_ram_to_vga
// Self-checking bench for ram_to_vga using reduced timing so several frames
// fit in a short run: 64x48 visible, line 80, frame 55 lines (4400 cycles).
// A position-based model (row-major address = (v-y0)*w + (h-x0)) predicts
// every output each cycle; literal checks pin the model at chosen points.
// RAM model returns addr[7:0] combinationally from the registered address.
// ---------------------------------------------------------------------------
module tb_ram_to_vga;

    localparam int HV = 64, HFP = 4, HS = 8, HBP = 4;
    localparam int VV = 48, VFP = 2, VS = 2, VBP = 3;
    localparam int HT = HV + HFP + HS + HBP;
    localparam int VT = VV + VFP + VS + VBP;
    localparam int F  = HT * VT;

    logic        clk;
    logic        reset;
    logic [9:0]  img_w;
    logic [9:0]  img_h;
    logic        frame_valid;
    logic [18:0] ram_rdaddr;
    logic        ram_rden;
    logic [7:0]  ram_rddata;
    logic [7:0]  pixel;
    logic        blank, hsync, vsync, frame_start;

    ram_to_vga #(
        .H_VIS(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VIS(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .RD_LAT(1)
    ) dut (
        .clk(clk), .reset(reset), .img_w(img_w), .img_h(img_h),
        .frame_valid(frame_valid), .ram_rdaddr(ram_rdaddr), .ram_rden(ram_rden),
        .ram_rddata(ram_rddata), .pixel(pixel), .blank(blank), .hsync(hsync),
        .vsync(vsync), .frame_start(frame_start)
    );

    assign ram_rddata = ram_rdaddr[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    int gw [8];
    int gh [8];
    bit gf [8];
    int rden_n [8], first_a [8], last_a [8], hs_low [8], vs_low [8], fs_n [8];
    int last_addr;

    // Cycles since reset release; equals the counter position index.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model of what the counters at position index c imply.
    function automatic void model(input int c, output bit win, output bit vis,
                                  output int h, output int v, output int addr, output bit ring);
        int fr, p, w, hh, x0, y0;
        fr   = (c / F) & 7;
        p    = c % F;
        h    = p % HT;
        v    = p / HT;
        w    = gw[fr];
        hh   = gh[fr];
        x0   = (HV - w) / 2;
        y0   = (VV - hh) / 2;
        win  = (h >= x0) && (h < x0 + w) && (v >= y0) && (v < y0 + hh);
        vis  = (h < HV) && (v < VV);
        addr = (v - y0) * w + (h - x0);
        ring = vis && !win && (h >= x0 - 1) && (h <= x0 + w) && (v >= y0 - 1) && (v <= y0 + hh);
    endfunction

    function automatic int clampi(input int x, input int mx);
        if (x == 0) return 1;
        if (x > mx) return mx;
        return x;
    endfunction

    // Per-cycle compare of all outputs against the model, plus statistics.
    always @(negedge clk) begin
        logic [31:0] act, exp;
        bit win, vis, ring;
        int h, v, a, fr;
        logic [7:0] e_pix;
        logic e_rden;
        act = {pixel, blank, hsync, vsync, frame_start, ram_rden, ram_rdaddr};
        if (reset) begin
            exp = {8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0};
            last_addr = 0;
            gw[0] = 1; gh[0] = 1; gf[0] = 1'b0;
            for (int i = 0; i < 8; i++) begin
                rden_n[i] = 0; first_a[i] = 0; last_a[i] = 0;
                hs_low[i] = 0; vs_low[i] = 0; fs_n[i] = 0;
            end
        end else begin
            e_rden = 1'b0;
            if (cyc >= 1) begin
                model(cyc - 1, win, vis, h, v, a, ring);
                if (win && gf[((cyc - 1) / F) & 7]) begin
                    e_rden = 1'b1;
                    last_addr = a;
                end
            end
            exp[13:0] = {1'b0, 1'b0, 1'b0, 1'b0, e_rden, 9'd0};
            exp[18:0] = 19'(last_addr);
            exp[19]   = e_rden;
            if (cyc >= 2) begin
                model(cyc - 2, win, vis, h, v, a, ring);
                fr = ((cyc - 2) / F) & 7;
                if (win && gf[fr]) e_pix = 8'(a % 256);
`ifdef BORDER_EN
                else if (ring) e_pix = 8'hFF;
`endif
                else e_pix = 8'h00;
                exp[31:20] = {e_pix, !vis,
                              !((h >= HV + HFP) && (h < HV + HFP + HS)),
                              !((v >= VV + VFP) && (v < VV + VFP + VS)),
                              (h == 0) && (v == 0)};
                if (!hsync) hs_low[fr]++;
                if (!vsync) vs_low[fr]++;
                if (frame_start) fs_n[fr]++;
            end else begin
                exp[31:20] = {8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
            end
            if (cyc >= 1 && ram_rden) begin
                fr = ((cyc - 1) / F) & 7;
                if (rden_n[fr] == 0) first_a[fr] = int'(ram_rdaddr);
                last_a[fr] = int'(ram_rdaddr);
                rden_n[fr]++;
            end
            if (cyc % F == F - 1) begin
                fr = (cyc / F + 1) & 7;
                gw[fr] = clampi(int'(img_w), HV);
                gh[fr] = clampi(int'(img_h), VV);
                gf[fr] = frame_valid;
            end
        end
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d outputs {pix,blank,hs,vs,fs,rden,addr}: got %h want %h", cyc, act, exp);
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Check the output pixel produced for counter position (h,v) of frame fr.
    task automatic chk_px(input string name, input int fr, input int h, input int v,
                          input logic [7:0] epix, input logic eblank);
        goto(fr * F + v * HT + h + 2);
        chk(name, {pixel, blank}, {epix, eblank});
    endtask

    task automatic chk_reset(input string tag);
        chk(tag, {pixel, blank, hsync, vsync, frame_start, ram_rden, ram_rdaddr},
            {8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 19'd0});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; img_w = 10'd32; img_h = 10'd24; frame_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset("reset_values");
        #2 reset = 1'b0;
        frame_valid = 1'b1;

        // Frame 1: 32x24 -> x0=16, y0=12, addr 0..767.
`ifdef BORDER_EN
        chk_px("border_top_30_11", 1, 30, 11, 8'hFF, 1'b0);
`endif
        chk_px("px_16_12", 1, 16, 12, 8'h00, 1'b0);
        chk_px("px_17_12", 1, 17, 12, 8'h01, 1'b0);
        goto(F + 20 * HT);
        #2 img_w = 10'd8; img_h = 10'd6;
        chk_px("px_14_20_black", 1, 14, 20, 8'h00, 1'b0);
`ifdef BORDER_EN
        chk_px("border_left_15_20", 1, 15, 20, 8'hFF, 1'b0);
        chk_px("border_right_48_20", 1, 48, 20, 8'hFF, 1'b0);
`endif
        chk_px("px_47_35_last", 1, 47, 35, 8'hFF, 1'b0);
`ifdef BORDER_EN
        chk_px("border_bot_30_36", 1, 30, 36, 8'hFF, 1'b0);
`endif
        // Frame 2: 8x6 -> x0=28, y0=21, addr 0..47.
        chk_px("px_28_21", 2, 28, 21, 8'h00, 1'b0);
        chk_px("px_29_21", 2, 29, 21, 8'h01, 1'b0);
        chk_px("px_35_26_last", 2, 35, 26, 8'h2F, 1'b0);
        chk_px("px_64_26_hblank", 2, 64, 26, 8'h00, 1'b1);

        goto(3 * F + 10);
        chk("f0_hsync_low_cycles", 32'(hs_low[0]), 32'd440);
        chk("f0_vsync_low_cycles", 32'(vs_low[0]), 32'd160);
        chk("f0_frame_start_count", 32'(fs_n[0]), 32'd1);
        chk("f0_rden_count", 32'(rden_n[0]), 32'd0);
        chk("f1_rden_count", 32'(rden_n[1]), 32'd768);
        chk("f1_first_addr", 32'(first_a[1]), 32'd0);
        chk("f1_last_addr", 32'(last_a[1]), 32'd767);
        chk("f1_frame_start_count", 32'(fs_n[1]), 32'd1);
        chk("f2_rden_count", 32'(rden_n[2]), 32'd48);
        chk("f2_first_addr", 32'(first_a[2]), 32'd0);
        chk("f2_last_addr", 32'(last_a[2]), 32'd47);

        // Reset at counter (40,30) of frame 3; new inputs need clamping.
        goto(3 * F + 30 * HT + 40);
        #2 img_w = 10'd100; img_h = 10'd0; reset = 1'b1;
        #1 chk_reset("midframe_reset_values");
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;

        // Epoch 2 frame 1: clamped 64x1 -> x0=0, y0=23, addr 0..63.
        chk_px("e2_px_10_21_black", 1, 10, 21, 8'h00, 1'b0);
`ifdef BORDER_EN
        chk_px("e2_border_10_22", 1, 10, 22, 8'hFF, 1'b0);
`endif
        chk_px("e2_px_0_23", 1, 0, 23, 8'h00, 1'b0);
        chk_px("e2_px_63_23", 1, 63, 23, 8'h3F, 1'b0);
`ifdef BORDER_EN
        chk_px("e2_border_10_24", 1, 10, 24, 8'hFF, 1'b0);
`endif
        goto(2 * F + 10);
        chk("e2_f0_rden_count", 32'(rden_n[0]), 32'd0);
        chk("e2_f0_frame_start_count", 32'(fs_n[0]), 32'd1);
        chk("e2_f1_rden_count", 32'(rden_n[1]), 32'd64);
        chk("e2_f1_first_addr", 32'(first_a[1]), 32'd0);
        chk("e2_f1_last_addr", 32'(last_a[1]), 32'd63);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_to_vga.md
# ram_to_vga

Read side of the frame buffer that the ROM-to-RAM scaler fills. The block generates 640x480@60 VGA timing from a 25 MHz pixel clock and fetches pixels from the frame RAM read port. It outputs a centered image of run-time size (for example 320x240 replicated or 80x60 decimated) on an 8-bit grey pixel bus, with black outside the image window. It sits between the frame RAM read port and the VGA DAC/pins.

## Interface
Parameters:
- H_VIS, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch (line total 800)
- V_VIS, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch (frame total 525)
- RD_LAT, 1, cycles from ram_rdaddr update to valid ram_rddata (1 or 2)

Ports:
- clk  in  1  pixel clock, 25 MHz; all logic on rising edge
- reset  in  1  reset, asynchronous, active-high
- img_w  in  10  image width in pixels, 1..640
- img_h  in  10  image height in lines, 1..480
- frame_valid  in  1  high when the frame buffer holds a complete image (scaler done)
- ram_rdaddr  out  19  frame RAM read address
- ram_rden  out  1  read enable, high for in-window fetches
- ram_rddata  in  8  frame RAM read data
- pixel  out  8  grey pixel to DAC
- blank  out  1  high outside the 640x480 visible area
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- frame_start  out  1  one-cycle pulse at the first visible pixel of each frame

## Operation
- Counters h_cnt 0..799 and v_cnt 0..524. h_cnt wraps at 799 and increments v_cnt; v_cnt wraps 524->0.
- hsync is low for h_cnt in [656,751]. vsync is low for v_cnt in [490,491]. The visible area is h_cnt<640 and v_cnt<480.
- Frame latch: at h_cnt=799, v_cnt=524 the block latches img_w, img_h and frame_valid into wl, hl and fv. Inputs that change mid-frame take effect on the next frame only.
- Clamping: wl>640 is clamped to 640 and wl=0 to 1; hl is clamped the same way to 480 and 1.
- Window origin: x0=(640-wl)>>1 and y0=(480-hl)>>1, both truncating. The window is x0<=h_cnt<x0+wl and y0<=v_cnt<y0+hl.
- Address generation is incremental; no multiplier is used:
  - at the frame latch point, addr is set to 0;
  - each in-window pixel presents addr on ram_rdaddr, asserts ram_rden, then increments addr;
  - addr is never reset between lines, so the image is read row-major at stride wl.
- Pixel source: an in-window pixel with fv=1 takes ram_rddata. Otherwise pixel=0, whether out-of-window, blank, or fv=0. When fv=0, ram_rden stays low and addr does not advance.
- ram_rdaddr holds its last value when ram_rden is low.
- Reset mid-frame: all state clears immediately and asynchronously. Counting restarts at (0,0) with wl, hl and fv cleared, so the first frame after reset is black.

## Timing
- Reset values:
  - h_cnt=0, v_cnt=0, addr=0
  - ram_rdaddr=0, ram_rden=0
  - pixel=0, blank=1, hsync=1, vsync=1, frame_start=0
  - wl=1, hl=1, fv=0
- ram_rdaddr and ram_rden are registered: they are valid 1 cycle after the counter state that generated them.
- pixel, blank, hsync, vsync and frame_start are registered through a delay line of RD_LAT+1 stages. All five outputs stay mutually aligned and lag the counters by exactly RD_LAT+1 cycles, so each pixel meets its own sync and blank.
- frame_start is high for 1 cycle, aligned with the output of pixel (0,0).
- Throughput: one pixel per clock with no stall path. ram_rddata is sampled unconditionally RD_LAT cycles after the fetch.

## Configuration
- BORDER_EN defined:
  - pixel forces 8'hFF on the one-pixel ring just outside the window: h_cnt=x0-1 or x0+wl, v_cnt=y0-1 or y0+hl, bounded to the ring rows and columns;
  - ring pixels lying outside the visible area are dropped;
  - the border is drawn even when fv=0.
- BORDER_EN undefined: no border logic is compiled, and out-of-window pixels are always 0.

## Test plan
- Reset release, frame_valid=0: hsync low for 96 cycles every 800, and vsync low for 2 lines every 525. pixel stays 0 throughout, ram_rden never rises, and frame_start pulses once per 420000 cycles.
- img_w=320, img_h=240, frame_valid=1, RAM model returns addr[7:0]:
  - window is x 160..479, y 120..359;
  - first fetch address is 0 and the last is 76799;
  - output at (160,120) is 8'h00 and at (161,120) is 8'h01, each aligned with blank=0.
- img_w=80, img_h=60: x0=280, y0=210. Exactly 4800 ram_rden cycles per frame, and the address wraps to 0 at the next frame.
- Change img_w from 320 to 80 at v_cnt=200: the current frame keeps 320 geometry, and the next frame uses 80.
- Assert reset at h_cnt=400, v_cnt=300: outputs return to their reset values within the same cycle, and after release counting restarts at (0,0) with a black first frame.
- With BORDER_EN and img_w=320, img_h=240: pixel=8'hFF at (159,200), (480,200), (300,119) and (300,360), and pixel=0 at (158,200).
